// File: rtl/sha2_pkg.sv
// Shared SHA-2 definitions: word width, SHA-256 block/round counts,
// the small sigma functions used by the message schedule and compression stage,
// and the schedule controller state type.
package sha2_pkg;

   localparam int WORD_W        = 32;
   localparam int SHA256_NUM_IN = 16;
   localparam int SHA256_ROUNDS = 64;

   typedef enum logic {
      LOAD = 1'b0,
      EMIT = 1'b1
   } sched_state_t;

   // sigma0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x)
   function automatic logic [WORD_W-1:0] sha256_ssig0(input logic [WORD_W-1:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
   endfunction

   // sigma1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x)
   function automatic logic [WORD_W-1:0] sha256_ssig1(input logic [WORD_W-1:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
   endfunction

endpackage

// File: rtl/adder32.sv
// Purpose: 32-bit modular adder, carry-out discarded (sum = a + b mod 2^32).
// Latency: combinational. Backpressure: none (pure datapath).
// Ports: a, b - addends; sum - truncated result.
module adder32 (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] sum
);

   assign sum = a + b;

endmodule

// File: rtl/sha256_msg_schedule.sv
// Purpose: SHA-256 message schedule; loads 16 words, emits W[0..63] in order.
// Latency: first w_valid the cycle after the 16th load handshake; 1 word/cycle.
// Backpressure: w_ready low freezes window, w_out and w_idx; in_ready only in LOAD.
// Ports: clk/rst (sync, active-high); in_valid/in_ready/in_word load side;
//        w_valid/w_ready/w_out/w_idx emit side; done pulses after W[63] handshake.
module sha256_msg_schedule
   import sha2_pkg::*;
#(
   parameter int NUM_IN = SHA256_NUM_IN,
   parameter int ROUNDS = SHA256_ROUNDS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] in_word,
   output logic              w_valid,
   input  logic              w_ready,
   output logic [WORD_W-1:0] w_out,
   output logic [5:0]        w_idx,
   output logic              done
);

   localparam int         LCNT_W    = $clog2(NUM_IN);
   localparam [LCNT_W-1:0] LAST_LOAD = LCNT_W'(NUM_IN - 1);
   localparam [5:0]        LAST_T    = 6'(ROUNDS - 1);
   // From this index on, the word shifted in would be W[64+] and is never emitted.
   localparam [5:0]        FILL_T    = 6'(ROUNDS - NUM_IN);

   sched_state_t      state;
   logic [LCNT_W-1:0] load_cnt;
   logic [5:0]        t;
   logic [WORD_W-1:0] win [NUM_IN];

   logic [WORD_W-1:0] s0, s1, sum_a, sum_b, next_w, shift_in;
   logic              shift_en;

   // W[t+16] = ssig1(W[t+14]) + W[t+9] + ssig0(W[t+1]) + W[t], as a two-level adder tree.
   assign s1 = sha256_ssig1(win[14]);
   assign s0 = sha256_ssig0(win[1]);

   adder32 u_add_a (.a(s1),    .b(win[9]), .sum(sum_a));
   adder32 u_add_b (.a(s0),    .b(win[0]), .sum(sum_b));
   adder32 u_add_c (.a(sum_a), .b(sum_b),  .sum(next_w));

   assign shift_en = (state == LOAD) ? in_valid : w_ready;
   assign shift_in = (state == LOAD) ? in_word
                   : (t >= FILL_T)   ? '0
                   : next_w;

   assign in_ready = (state == LOAD);
   assign w_valid  = (state == EMIT);
   assign w_out    = win[0];
   assign w_idx    = t;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= LOAD;
         load_cnt <= '0;
         t        <= '0;
         done     <= 1'b0;
         for (int i = 0; i < NUM_IN; i++) win[i] <= '0;
      end else begin
         done <= 1'b0;

         if (shift_en) begin
            for (int i = 0; i < NUM_IN - 1; i++) win[i] <= win[i+1];
            win[NUM_IN-1] <= shift_in;
         end

         unique case (state)
            LOAD: begin
               if (in_valid) begin
                  load_cnt <= load_cnt + LCNT_W'(1);
                  if (load_cnt == LAST_LOAD) begin
                     state    <= EMIT;
                     load_cnt <= '0;
                     t        <= '0;
                  end
               end
            end
            EMIT: begin
               if (w_ready) begin
                  t <= t + 6'd1;
                  if (t == LAST_T) begin
                     state <= LOAD;
                     t     <= '0;
                     done  <= 1'b1;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
module tb_sha256_msg_schedule;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_word;
   logic        w_valid;
   logic        w_ready;
   logic [31:0] w_out;
   logic [5:0]  w_idx;
   logic        done;

   int errors = 0;
   int checks = 0;

   sha256_msg_schedule dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_word  (in_word),
      .w_valid  (w_valid),
      .w_ready  (w_ready),
      .w_out    (w_out),
      .w_idx    (w_idx),
      .done     (done)
   );

   always #5 clk = ~clk;

   // Observations from the most recent run_block call.
   logic [31:0] obs_w   [64];
   logic [5:0]  obs_idx [64];
   int          obs_cyc [64];
   int          n_obs, cyc, done_cnt, done_at, rdy_bad, hold_bad;
   bit          done_rdy, timed_out;
   logic [31:0] stall_w;
   logic [5:0]  stall_i;

   logic [31:0] abc_blk [16];
   logic [31:0] ref_w   [64];

   // Reference model: textbook SHA-256 message expansion.
   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic void ref_sched(input logic [31:0] m[16], output logic [31:0] w[64]);
      for (int t = 0; t < 64; t++) begin
         if (t < 16) w[t] = m[t];
         else w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10))
                   + w[t-7]
                   + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3))
                   + w[t-16];
      end
   endfunction

   // Drives one block and records what comes out. Inputs are set and outputs
   // sampled on the falling edge; cyc numbers the cycle whose outputs are visible.
   task automatic run_block(input logic [31:0] blk[16], input bit gaps, input int stall_t,
                            input int stall_len, input bit rnd, input bit toggle, input int abort_t);
      int k;
      int stalled;
      k = 0; stalled = 0; n_obs = 0; cyc = 1; done_cnt = 0; done_at = 0;
      rdy_bad = 0; hold_bad = 0; done_rdy = 0; timed_out = 0;
      stall_w = 'x; stall_i = 'x;
      for (int i = 0; i < 64; i++) begin obs_w[i] = 'x; obs_idx[i] = 'x; obs_cyc[i] = -1; end
      while ((k < 16 || n_obs < 64) && cyc < 1000) begin
         if (abort_t >= 0 && w_valid === 1'b1 && w_idx == 6'(abort_t)) break;
         if (k < 16) begin
            in_valid = gaps ? cyc[0] : 1'b1;
            in_word  = blk[k];
         end else begin
            in_valid = toggle ? 1'($urandom_range(0, 1)) : 1'b0;
            in_word  = $urandom;
         end
         w_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (stall_len > 0 && w_valid === 1'b1 && w_idx == 6'(stall_t) && stalled < stall_len) begin
            if (stalled == 0) begin stall_w = w_out; stall_i = w_idx; end
            else if (w_out !== stall_w || w_idx !== stall_i) hold_bad++;
            w_ready = 1'b0;
            stalled++;
         end
         if (in_valid && in_ready === 1'b1) k++;
         if (w_valid === 1'b1) begin
            if (in_ready !== 1'b0) rdy_bad++;
            if (w_ready && n_obs < 64) begin
               obs_w[n_obs] = w_out; obs_idx[n_obs] = w_idx; obs_cyc[n_obs] = cyc;
               n_obs++;
            end
         end
         @(negedge clk);
         cyc++;
         if (done === 1'b1) begin done_cnt++; done_at = cyc; done_rdy = in_ready; end
      end
      timed_out = (cyc >= 1000);
      in_valid = 1'b0;
      w_ready  = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; w_ready = 1'b0; in_word = '0;
      @(negedge clk); @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
      checks++; if (w_valid !== 1'b0) begin errors++; $display("FAIL reset w_valid: got %b want 0", w_valid); end
      checks++; if (w_out !== 32'h0) begin errors++; $display("FAIL reset w_out: got %h want 0", w_out); end
      checks++; if (w_idx !== 6'd0) begin errors++; $display("FAIL reset w_idx: got %0d want 0", w_idx); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset done: got %b want 0", done); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_abc();
      int extra;
      ref_sched(abc_blk, ref_w);
      run_block(abc_blk, 0, 0, 0, 0, 0, -1);
      checks++; if (timed_out || n_obs != 64) begin errors++; $display("FAIL abc count: got %0d words (timeout=%0d) want 64", n_obs, timed_out); end
      checks++; if (obs_w[16] !== 32'h61626380) begin errors++; $display("FAIL abc W16: got %h want 61626380", obs_w[16]); end
      checks++; if (obs_w[17] !== 32'h000F0000) begin errors++; $display("FAIL abc W17: got %h want 000f0000", obs_w[17]); end
      checks++; if (obs_w[18] !== 32'h7DA86405) begin errors++; $display("FAIL abc W18: got %h want 7da86405", obs_w[18]); end
      checks++; if (obs_w[19] !== 32'h600003C6) begin errors++; $display("FAIL abc W19: got %h want 600003c6", obs_w[19]); end
      checks++; if (obs_w[63] !== 32'h12B1EDEB) begin errors++; $display("FAIL abc W63: got %h want 12b1edeb", obs_w[63]); end
      for (int i = 0; i < 64; i++) begin
         checks++;
         if (obs_w[i] !== ref_w[i] || obs_idx[i] !== 6'(i) || obs_cyc[i] != 17 + i) begin
            errors++;
            $display("FAIL abc W[%0d]: got %h idx %0d cycle %0d want %h idx %0d cycle %0d",
                     i, obs_w[i], obs_idx[i], obs_cyc[i], ref_w[i], i, 17 + i);
         end
      end
      checks++; if (done_cnt != 1 || done_at != 81) begin errors++; $display("FAIL abc done: got %0d pulses last at cycle %0d want 1 at 81", done_cnt, done_at); end
      checks++; if (done_rdy !== 1'b1) begin errors++; $display("FAIL abc in_ready in done cycle: got %b want 1", done_rdy); end
      extra = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (done !== 1'b0 || w_valid !== 1'b0) extra++;
      end
      checks++; if (extra != 0) begin errors++; $display("FAIL abc idle after done: got %0d busy cycles want 0", extra); end
   endtask

   task automatic test_zero();
      logic [31:0] zb [16];
      for (int i = 0; i < 16; i++) zb[i] = '0;
      run_block(zb, 0, 0, 0, 0, 0, -1);
      for (int i = 0; i < 64; i++) begin
         checks++;
         if (obs_w[i] !== 32'h0 || obs_idx[i] !== 6'(i) || obs_cyc[i] != 17 + i) begin
            errors++;
            $display("FAIL zero W[%0d]: got %h idx %0d cycle %0d want 0 idx %0d cycle %0d",
                     i, obs_w[i], obs_idx[i], obs_cyc[i], i, 17 + i);
         end
      end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL zero done: got %0d pulses want 1", done_cnt); end
   endtask

   task automatic test_gaps_stall();
      ref_sched(abc_blk, ref_w);
      run_block(abc_blk, 1, 20, 3, 0, 0, -1);
      for (int i = 0; i < 64; i++) begin
         checks++;
         if (obs_w[i] !== ref_w[i] || obs_idx[i] !== 6'(i)) begin
            errors++;
            $display("FAIL stall W[%0d]: got %h idx %0d want %h idx %0d", i, obs_w[i], obs_idx[i], ref_w[i], i);
         end
      end
      checks++; if (stall_w !== ref_w[20] || stall_i !== 6'd20) begin errors++; $display("FAIL stall held value: got %h idx %0d want %h idx 20", stall_w, stall_i, ref_w[20]); end
      checks++; if (hold_bad != 0) begin errors++; $display("FAIL stall hold: got %0d changed cycles want 0", hold_bad); end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL stall done: got %0d pulses want 1", done_cnt); end
   endtask

   task automatic test_emit_toggle();
      ref_sched(abc_blk, ref_w);
      run_block(abc_blk, 0, 0, 0, 0, 1, -1);
      checks++; if (rdy_bad != 0) begin errors++; $display("FAIL toggle in_ready in EMIT: got %0d high cycles want 0", rdy_bad); end
      for (int i = 0; i < 64; i++) begin
         checks++;
         if (obs_w[i] !== ref_w[i] || obs_idx[i] !== 6'(i)) begin
            errors++;
            $display("FAIL toggle W[%0d]: got %h idx %0d want %h idx %0d", i, obs_w[i], obs_idx[i], ref_w[i], i);
         end
      end
   endtask

   task automatic test_reset_mid();
      ref_sched(abc_blk, ref_w);
      run_block(abc_blk, 0, 0, 0, 0, 0, 30);
      checks++; if (n_obs != 30 || w_idx !== 6'd30) begin errors++; $display("FAIL midreset reach t=30: got %0d words idx %0d want 30", n_obs, w_idx); end
      rst = 1'b1; in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || w_valid !== 1'b0 || w_out !== 32'h0 || w_idx !== 6'd0 || done !== 1'b0) begin
         errors++;
         $display("FAIL midreset emit: got rdy=%b vld=%b w=%h idx=%0d done=%b want 1 0 0 0 0",
                  in_ready, w_valid, w_out, w_idx, done);
      end
      // Partial load followed by reset must be discarded entirely.
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; in_word = $urandom;
         @(negedge clk);
      end
      rst = 1'b1; in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || w_valid !== 1'b0 || w_out !== 32'h0) begin
         errors++;
         $display("FAIL midreset load: got rdy=%b vld=%b w=%h want 1 0 0", in_ready, w_valid, w_out);
      end
      run_block(abc_blk, 0, 0, 0, 0, 0, -1);
      for (int i = 0; i < 64; i++) begin
         checks++;
         if (obs_w[i] !== ref_w[i] || obs_idx[i] !== 6'(i) || obs_cyc[i] != 17 + i) begin
            errors++;
            $display("FAIL midreset reload W[%0d]: got %h idx %0d cycle %0d want %h idx %0d cycle %0d",
                     i, obs_w[i], obs_idx[i], obs_cyc[i], ref_w[i], i, 17 + i);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] blk_a [16];
      logic [31:0] blk_b [16];
      logic [31:0] ref_b [64];
      for (int i = 0; i < 16; i++) begin blk_a[i] = $urandom; blk_b[i] = $urandom; end
      ref_sched(blk_a, ref_w);
      ref_sched(blk_b, ref_b);
      run_block(blk_a, 0, 0, 0, 0, 0, -1);
      for (int i = 0; i < 64; i++) begin
         checks++;
         if (obs_w[i] !== ref_w[i]) begin errors++; $display("FAIL b2b A W[%0d]: got %h want %h", i, obs_w[i], ref_w[i]); end
      end
      checks++; if (done_cnt != 1 || done_at != 81) begin errors++; $display("FAIL b2b A done: got %0d at %0d want 1 at 81", done_cnt, done_at); end
      // Block B starts in A's done cycle; an on-time done at 81 proves W0 was taken there.
      run_block(blk_b, 0, 0, 0, 0, 0, -1);
      for (int i = 0; i < 64; i++) begin
         checks++;
         if (obs_w[i] !== ref_b[i] || obs_idx[i] !== 6'(i)) begin
            errors++;
            $display("FAIL b2b B W[%0d]: got %h idx %0d want %h idx %0d", i, obs_w[i], obs_idx[i], ref_b[i], i);
         end
      end
      checks++; if (done_cnt != 1 || done_at != 81) begin errors++; $display("FAIL b2b B done: got %0d at %0d want 1 at 81", done_cnt, done_at); end
   endtask

   task automatic test_random();
      logic [31:0] blk [16];
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < 16; i++) blk[i] = $urandom;
         ref_sched(blk, ref_w);
         run_block(blk, 1'($urandom_range(0, 1)), 0, 0, 1, 1, -1);
         checks++; if (timed_out || rdy_bad != 0 || done_cnt != 1) begin errors++; $display("FAIL random %0d control: timeout=%0d rdy_bad=%0d done=%0d want 0 0 1", r, timed_out, rdy_bad, done_cnt); end
         for (int i = 0; i < 64; i++) begin
            checks++;
            if (obs_w[i] !== ref_w[i] || obs_idx[i] !== 6'(i)) begin
               errors++;
               $display("FAIL random %0d W[%0d]: got %h idx %0d want %h idx %0d", r, i, obs_w[i], obs_idx[i], ref_w[i], i);
            end
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) abc_blk[i] = 32'h0;
      abc_blk[0]  = 32'h61626380;
      abc_blk[15] = 32'h00000018;

      test_reset();
      test_abc();
      test_zero();
      test_gaps_stall();
      test_emit_toggle();
      test_reset_mid();
      test_back_to_back();
      test_random();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sha256_msg_schedule.md
# sha256_msg_schedule

Sequential SHA-256 message-schedule generator that sits directly upstream of the 32-bit modular adder datapath in the compression round. It accepts one 512-bit message block as sixteen 32-bit words over a valid/ready handshake. It then emits the 64 schedule words W[0..63] in order, one per cycle under downstream backpressure. W[t≥16] is formed by four-operand mod-2^32 addition.

## Interface
- `NUM_IN`, 16, number of input words per block (fixed for SHA-256)
- `ROUNDS`, 64, number of schedule words emitted per block
- `clk`  input  1  single clock; all state updates on rising edge
- `rst`  input  1  reset, synchronous, active-high
- `in_valid`  input  1  `in_word` holds a valid message word
- `in_ready`  output  1  block can accept a word (high only in LOAD)
- `in_word`  input  32  message word, big-endian word order, W[0] first
- `w_valid`  output  1  `w_out` holds schedule word W[`w_idx`]
- `w_ready`  input  1  downstream accepts `w_out` this cycle
- `w_out`  output  32  schedule word
- `w_idx`  output  6  index t of `w_out`, 0..63
- `done`  output  1  one-cycle pulse after W[63] is accepted

## Operation
- Window register `win[0..15]` (16×32) holds W[t..t+15]. `w_out` = `win[0]`.
- States:
  - LOAD: `in_ready`=1. Each in handshake shifts `in_word` into `win[15]` and shifts the rest down by one. The load counter increments on each handshake. On the 16th handshake the block enters EMIT with t=0.
  - EMIT: `w_valid`=1 and `in_ready`=0. On each out handshake (`w_valid`&`w_ready`), the window shifts down by one and `win[15]` ← next. t then increments.
- Next-word computation, mod 2^32 with carry-out discarded: next = σ1(`win[14]`) + `win[9]` + σ0(`win[1]`) + `win[0]`.
  - σ0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x).
  - σ1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
- For t ≥ 48, the value shifted in is don't-care; the block shifts in 0.
- The handshake with t=63 returns the block to LOAD and registers `done`=1 for exactly the next cycle.
- Words presented in EMIT are ignored, and no handshake occurs (`in_ready`=0).
- `w_ready` low in EMIT holds `w_out`, `w_idx`, and the window stable.
- `in_valid` low in LOAD holds the load count; gaps are allowed.

## Timing
- Reset values: state=LOAD, `in_ready`=1, `w_valid`=0, `w_out`=0, `w_idx`=0, `done`=0, window all 0, load count 0.
- Reset asserted mid-LOAD or mid-EMIT aborts the block. The next cycle shows reset values, and partial data is discarded.
- First `w_valid` occurs in the cycle after the 16th input handshake.
- Throughput is one word per cycle each way. A block with no stalls takes 16 + 64 = 80 cycles. `done` is high in cycle 81, the same cycle `in_ready` is already 1.
- A new block's first word may be accepted in the `done` cycle.
- The next-word adder path is combinational from the window and is registered into `win[15]`. Latency from output handshake to the next `w_out` is 1 cycle.

## Structure
- Shared package `sha2_pkg`:
  - `WORD_W`=32, `SHA256_NUM_IN`=16, `SHA256_ROUNDS`=64.
  - Functions `sha256_ssig0` and `sha256_ssig1` (small sigmas), reused by the compression stage.
  - State enum {LOAD, EMIT}.
- The four-operand sum is built as a tree of three existing `adder32` instances, with no new adder sub-module.
- Everything else is local to `sha256_msg_schedule`.

## Test plan
- "abc" padded block (W0=0x61626380, W1..W14=0, W15=0x00000018), `w_ready` held 1:
  - W16=0x61626380, W17=0x000F0000, W18=0x7DA86405, W19=0x600003C6, W63=0x12B1EDEB.
  - `done` pulses once, in cycle 81.
- All-zero block → all 64 outputs are 0, with `w_idx` stepping 0..63 one per cycle.
- Load with `in_valid` gaps (words on alternate cycles) and backpressure (`w_ready` low for 3 cycles at t=20):
  - Outputs match the no-stall "abc" sequence exactly.
  - `w_out`=W20 and `w_idx`=20 are held during the stall.
- `in_valid` toggling during EMIT → `in_ready`=0 and the output sequence is unaffected.
- `rst` pulsed at t=30 → the next cycle shows all reset values. A fresh "abc" load then reproduces W0..W63 correctly.
- Back-to-back blocks: second block's W0 is presented in the `done` cycle and accepted. Its 64 outputs are correct, with no `done` in between.
